// File: rtl/yokyo_mem_pkg.sv
// Shared encodings and lane helpers for the core-to-AXI4-lite memory bridge.
// Pure functions so the sizing rules live in one place.
package yokyo_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW_W,
        B,
        RESP
    } state_e;

    function automatic logic [3:0] strb_of(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [3:0] s;
        case (size)
            SIZE_B:  s = 4'b0001 << a;
            SIZE_H:  s = 4'b0011 << a;
            SIZE_W:  s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] wlane(
        input logic [1:0]  size,
        input logic [31:0] d
    );
        logic [31:0] w;
        case (size)
            SIZE_B:  w = {4{d[7:0]}};
            SIZE_H:  w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rext(
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  a,
        input logic [31:0] rdata
    );
        logic [31:0] lane;
        logic [31:0] r;
        lane = rdata >> {a, 3'b000};
        case (size)
            SIZE_B:  r = {{24{sgn & lane[7]}}, lane[7:0]};
            SIZE_H:  r = {{16{sgn & lane[15]}}, lane[15:0]};
            default: r = lane;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic m;
        case (size)
            SIZE_H:  m = a[0];
            SIZE_W:  m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: write strobes, store replication
// and load lane extraction with sign/zero extension.
module mem_lane_align
    import yokyo_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sgn_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        wstrb_o = strb_of(size_i, addr_i);
        wdata_o = wlane(size_i, wdata_i);
        rdata_o = rext(size_i, sgn_i, addr_i, rdata_i);
    end

endmodule

// File: rtl/mem_axi_bridge.sv
// Single-outstanding bridge from the core load/store port to AXI4-lite.
// Requests are pre-checked for size, alignment and range before any bus traffic.
module mem_axi_bridge
    import yokyo_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        pre_err;
    logic        aw_done;
    logic        w_done;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    mem_lane_align u_align (
        .size_i  (size_q),
        .sgn_i   (sgn_q),
        .addr_i  (addr_q[1:0]),
        .wdata_i (wdata_q),
        .rdata_i (m_axi_rdata),
        .wstrb_o (lane_strb),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );

    assign pre_err = (req_size == 2'd3)
                  || misaligned(req_size, req_addr[1:0])
                  || (req_addr >= ADDR_LIMIT);

    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q || m_axi_wready;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = pre_err;
                    if (pre_err) begin
                        state_d = RESP;
                    end else if (req_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end
                end
            end
            AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = lane_rdata;
                    err_d    = (m_axi_rresp == 2'b10) || (m_axi_rresp == 2'b11);
                    state_d  = RESP;
                end
            end
            AW_W: begin
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                // Both channels may finish on the same edge
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = B;
                end
            end
            B: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    err_d    = (m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11);
                    state_d  = RESP;
                end
            end
            RESP: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = rdata_q;
                resp_err_d   = err_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            sgn_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign m_axi_araddr  = {addr_q[31:2], 2'b00};
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign m_axi_awaddr  = {addr_q[31:2], 2'b00};
    assign m_axi_awvalid = awvalid_q;
    // Strobes only mean something while a write beat is offered
    assign m_axi_wstrb   = wvalid_q ? lane_strb : 4'b0000;
    assign m_axi_wdata   = lane_wdata;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Bench for mem_axi_bridge: vector table, AXI-lite slave model,
// response scoreboard, handshake stability checker and reset corner case.
module tb_mem_axi_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_rresp, m_axi_bresp;
    logic [3:0]  m_axi_wstrb;

    always #5 clk = ~clk;

    mem_axi_bridge dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .m_axi_araddr(m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- AXI-lite slave model ----------------
    int          cfg_aw_lat = 0, cfg_w_lat = 0;
    logic        cfg_r_hold = 1'b0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_resp = 2'b00;
    int          aw_cnt, w_cnt;
    logic        aw_done, w_done;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    int          ar_seen = 0, aw_seen = 0;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    assign m_axi_arready = 1'b1;
    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= cfg_aw_lat);
    assign m_axi_wready  = m_axi_wvalid && (w_cnt >= cfg_w_lat);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_cnt <= 0; w_cnt <= 0; aw_done <= 1'b0; w_done <= 1'b0;
            m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
        end else begin
            if (m_axi_arvalid) ar_seen <= ar_seen + 1;
            if (m_axi_awvalid) aw_seen <= aw_seen + 1;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs <= ar_hs + 1;
                cap_araddr <= m_axi_araddr;
                if (!cfg_r_hold) begin
                    m_axi_rvalid <= 1'b1;
                    m_axi_rdata  <= cfg_rdata;
                    m_axi_rresp  <= cfg_resp;
                end
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt <= 0; aw_done <= 1'b1; aw_hs <= aw_hs + 1;
                cap_awaddr <= m_axi_awaddr;
            end else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
            if (m_axi_wvalid && m_axi_wready) begin
                w_cnt <= 0; w_done <= 1'b1; w_hs <= w_hs + 1;
                cap_wdata <= m_axi_wdata; cap_wstrb <= m_axi_wstrb;
            end else if (m_axi_wvalid) w_cnt <= w_cnt + 1;
            if (aw_done && w_done && !m_axi_bvalid) begin
                m_axi_bvalid <= 1'b1; m_axi_bresp <= cfg_resp;
                aw_done <= 1'b0; w_done <= 1'b0;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0; b_hs <= b_hs + 1;
            end
        end
    end

    // ---------------- scoreboard and stability monitor ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int cyc = 0, acc_cyc = 0, accepts = 0, resps = 0, abandoned = 0;
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            p_arv = 1'b0; p_awv = 1'b0; p_wv = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                accepts++; acc_cyc = cyc;
            end
            if (resp_valid) begin
                exp_t e;
                resps++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    if (e.lat != 0) chk("latency", cyc - acc_cyc, e.lat);
                end
            end
            if (p_arv && !p_arr) begin
                chk("ar_hold", {31'd0, m_axi_arvalid}, 32'd1);
                chk("ar_stable", m_axi_araddr, p_araddr);
            end
            if (p_awv && !p_awr) begin
                chk("aw_hold", {31'd0, m_axi_awvalid}, 32'd1);
                chk("aw_stable", m_axi_awaddr, p_awaddr);
            end
            if (p_wv && !p_wr) begin
                chk("w_hold", {31'd0, m_axi_wvalid}, 32'd1);
                chk("w_stable", m_axi_wdata, p_wdata);
                chk("wstrb_stable", {28'd0, m_axi_wstrb}, {28'd0, p_wstrb});
            end
            p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
            p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
            p_wv = m_axi_wvalid; p_wr = m_axi_wready;
            p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] srdata;
        logic [1:0]  sresp;
        int          aw_lat;
        int          w_lat;
        logic        eerr;
        logic [31:0] erdata;
        logic        ebus;
        logic [31:0] ebaddr;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        int          elat;
    } vec_t;

    function automatic vec_t mkv(
        input logic we, input logic [1:0] size, input logic sgn,
        input logic [31:0] addr, input logic [31:0] wdata,
        input logic [31:0] srdata, input logic [1:0] sresp,
        input int aw_lat, input int w_lat, input logic eerr,
        input logic [31:0] erdata, input logic ebus,
        input logic [31:0] ebaddr, input logic [3:0] estrb,
        input logic [31:0] ewdata, input int elat);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.srdata = srdata; v.sresp = sresp;
        v.aw_lat = aw_lat; v.w_lat = w_lat; v.eerr = eerr;
        v.erdata = erdata; v.ebus = ebus; v.ebaddr = ebaddr;
        v.estrb = estrb; v.ewdata = ewdata; v.elat = elat;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int ar0, aw0, w0, b0, ars0, aws0, r0, n;
        logic ok;
        cfg_aw_lat = v.aw_lat; cfg_w_lat = v.w_lat;
        cfg_rdata = v.srdata; cfg_resp = v.sresp;
        ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        ars0 = ar_seen; aws0 = aw_seen; r0 = resps;
        sb_q.push_back('{rdata: v.erdata, err: v.eerr, lat: v.elat});
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = v.we; req_size = v.size;
        req_signed = v.sgn; req_addr = v.addr; req_wdata = v.wdata;
        n = 0;
        do begin
            ok = req_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 50);
        req_valid = 1'b0;
        if (!ok) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        n = 0;
        while (resps == r0 && n < 60) begin
            @(posedge clk); n++;
        end
        if (resps == r0) begin
            chk({tag, "_resp_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end
        @(posedge clk); #1;
        chk({tag, "_idle_after"}, {31'd0, req_ready}, 32'd1);
        if (!v.ebus) begin
            chk({tag, "_no_arvalid"}, ar_seen - ars0, 0);
            chk({tag, "_no_awvalid"}, aw_seen - aws0, 0);
        end else if (v.we) begin
            chk({tag, "_aw_count"}, aw_hs - aw0, 1);
            chk({tag, "_w_count"}, w_hs - w0, 1);
            chk({tag, "_b_count"}, b_hs - b0, 1);
            chk({tag, "_awaddr"}, cap_awaddr, v.ebaddr);
            chk({tag, "_wstrb"}, {28'd0, cap_wstrb}, {28'd0, v.estrb});
            chk({tag, "_wdata"}, cap_wdata, v.ewdata);
        end else begin
            chk({tag, "_ar_count"}, ar_hs - ar0, 1);
            chk({tag, "_araddr"}, cap_araddr, v.ebaddr);
        end
    endtask

    vec_t vt[16];

    initial begin
        int n;
        vt[0]  = mkv(1, 2, 0, 32'h100, 32'hDEAD_BEEF, 0, 2'b00, 0, 2, 0, 0, 1, 32'h100, 4'hF, 32'hDEAD_BEEF, 0);
        vt[1]  = mkv(1, 0, 0, 32'h103, 32'h1234_56A5, 0, 2'b00, 2, 0, 0, 0, 1, 32'h100, 4'b1000, 32'hA5A5_A5A5, 0);
        vt[2]  = mkv(1, 1, 0, 32'h002, 32'hCAFE_BEEF, 0, 2'b00, 1, 1, 0, 0, 1, 32'h000, 4'b1100, 32'hBEEF_BEEF, 0);
        vt[3]  = mkv(0, 1, 1, 32'h102, 0, 32'h8001_1234, 2'b00, 0, 0, 0, 32'hFFFF_8001, 1, 32'h100, 0, 0, 4);
        vt[4]  = mkv(0, 1, 0, 32'h102, 0, 32'h8001_1234, 2'b00, 0, 0, 0, 32'h0000_8001, 1, 32'h100, 0, 0, 4);
        vt[5]  = mkv(0, 0, 1, 32'h201, 0, 32'h1122_8033, 2'b00, 0, 0, 0, 32'hFFFF_FF80, 1, 32'h200, 0, 0, 0);
        vt[6]  = mkv(0, 0, 0, 32'h203, 0, 32'hF011_2233, 2'b00, 0, 0, 0, 32'h0000_00F0, 1, 32'h200, 0, 0, 0);
        vt[7]  = mkv(0, 2, 1, 32'h104, 0, 32'h89AB_CDEF, 2'b00, 0, 0, 0, 32'h89AB_CDEF, 1, 32'h104, 0, 0, 0);
        vt[8]  = mkv(0, 2, 0, 32'h102, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 2);
        vt[9]  = mkv(1, 3, 0, 32'h100, 32'h5555_5555, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 2);
        vt[10] = mkv(0, 2, 0, 32'h8000_0000, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 2);
        vt[11] = mkv(0, 1, 1, 32'h101, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vt[12] = mkv(0, 2, 0, 32'h7FFF_FFFC, 0, 32'h5555_AAAA, 2'b00, 0, 0, 0, 32'h5555_AAAA, 1, 32'h7FFF_FFFC, 0, 0, 4);
        vt[13] = mkv(0, 2, 0, 32'h40, 0, 32'h1234_5678, 2'b10, 0, 0, 1, 32'h1234_5678, 1, 32'h40, 0, 0, 0);
        vt[14] = mkv(1, 2, 0, 32'h44, 32'h0BAD_F00D, 0, 2'b11, 3, 1, 1, 0, 1, 32'h44, 4'hF, 32'h0BAD_F00D, 0);
        vt[15] = mkv(1, 2, 0, 32'h48, 32'h7777_0001, 0, 2'b01, 0, 0, 0, 0, 1, 32'h48, 4'hF, 32'h7777_0001, 0);

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_outputs", {27'd0, resp_valid, m_axi_arvalid, m_axi_awvalid,
                            m_axi_wvalid, m_axi_rready | m_axi_bready}, 32'd0);
        chk("rst_buses", m_axi_araddr | m_axi_awaddr | m_axi_wdata | resp_rdata
                         | {28'd0, m_axi_wstrb} | {31'd0, resp_err}, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vt[i], $sformatf("v%0d", i));

        // Reset while the bridge is waiting in R with rready raised
        cfg_r_hold = 1'b1;
        cfg_rdata = 32'hAAAA_5555; cfg_resp = 2'b00;
        sb_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 0});
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
        req_signed = 1'b0; req_addr = 32'h300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!m_axi_rready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("mid_r_reached", {31'd0, m_axi_rready}, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_rready", {31'd0, m_axi_rready}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_valids", {28'd0, m_axi_arvalid, m_axi_awvalid,
                               m_axi_wvalid, m_axi_bready}, 32'd0);
        chk("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
        sb_q.delete();
        abandoned++;
        @(posedge clk); #1;
        rstn = 1'b1;
        cfg_r_hold = 1'b0;
        run_vec(vt[7], "post_rst");

        repeat (3) @(posedge clk);
        chk("resp_per_accept", resps, accepts - abandoned);
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
